// File: rtl/encrypter_top_level.sv
// LFSR stream encrypter: frames a plaintext message with 0x7E padding and
// XORs each of the 64 frame bytes with a 5-bit LFSR, writing ciphertext to mem[64:127].

module enc_dat_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr_a,
  input  logic [7:0] raddr_b,
  output logic [7:0] rdata_a_c,
  output logic [7:0] rdata_b_c
);

  logic [7:0] core [256];

  always_ff @(posedge clk) begin
    if (we) begin
      core[waddr] <= wdata;
    end
  end

  assign rdata_a_c = core[raddr_a];
  assign rdata_b_c = core[raddr_b];

endmodule

module encrypter_top_level (
  input  logic       clk,
  input  logic       init,
  input  logic       wr_en,
  input  logic [7:0] waddr,
  input  logic [7:0] data_in,
  input  logic [7:0] raddr,
  output logic [7:0] data_out,
  output logic       done
);

  localparam int unsigned AW        = 8;
  localparam int unsigned DW        = 8;
  localparam int unsigned IW        = 6;
  localparam int unsigned LW        = 5;
  localparam int unsigned MSG_BASE  = 0;
  localparam int unsigned CFG_BASE  = 60;
  localparam int unsigned CT_BASE   = 64;
  localparam int unsigned MAX_LEN   = 50;
  localparam int unsigned PRE_MIN   = 7;
  localparam int unsigned PRE_MAX   = 12;
  localparam int unsigned LAST_IDX  = 63;
  localparam logic [DW-1:0] PAD     = 8'h7E;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q,   cnt_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [LW-1:0] lfsr_q,  lfsr_d;
  logic [LW-1:0] taps_q,  taps_d;
  logic [IW-1:0] len_q,   len_d;
  logic [3:0]    pre_q,   pre_d;
  logic          done_q,  done_d;

  logic          mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;
  logic [AW-1:0] int_raddr_c;
  logic [DW-1:0] int_rdata_c;
  logic [DW-1:0] frame_c;
  logic [6:0]    pos_c;
  logic [6:0]    msg_end_c;
  logic          in_msg_c;
  logic          host_ok_c;
  logic [LW-1:0] lfsr_step_c;

  function automatic logic [IW-1:0] clamp_len(input logic [DW-1:0] b);
    return (b > DW'(MAX_LEN)) ? IW'(MAX_LEN) : b[IW-1:0];
  endfunction

  function automatic logic [3:0] clamp_pre(input logic [DW-1:0] b);
    if (b < DW'(PRE_MIN)) begin
      return 4'(PRE_MIN);
    end else if (b > DW'(PRE_MAX)) begin
      return 4'(PRE_MAX);
    end
    return b[3:0];
  endfunction

  // Out-of-range pattern selects fall back to the 5'h17 polynomial.
  function automatic logic [LW-1:0] pat_taps(input logic [DW-1:0] b);
    case (b)
      8'd0:    return 5'h1E;
      8'd1:    return 5'h1D;
      8'd2:    return 5'h1B;
      8'd3:    return 5'h17;
      8'd4:    return 5'h14;
      8'd5:    return 5'h12;
      default: return 5'h17;
    endcase
  endfunction

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  function automatic logic [LW-1:0] seed_of(input logic [LW-1:0] b);
    return (b == '0) ? LW'(1) : b;
  endfunction

  enc_dat_mem dm1 (
    .clk       (clk),
    .we        (mem_we_c),
    .waddr     (mem_waddr_c),
    .wdata     (mem_wdata_c),
    .raddr_a   (raddr),
    .raddr_b   (int_raddr_c),
    .rdata_a_c (data_out),
    .rdata_b_c (int_rdata_c)
  );

  // Frame position decode and internal read address.
  always_comb begin
    pos_c       = {1'b0, idx_q};
    msg_end_c   = 7'(pre_q) + 7'(len_q);
    in_msg_c    = (pos_c >= 7'(pre_q)) && (pos_c < msg_end_c);
    int_raddr_c = AW'(CFG_BASE) + AW'(cnt_q);
    if (state_q == S_RUN) begin
      int_raddr_c = AW'(MSG_BASE) + AW'(idx_q) - AW'(pre_q);
    end
    frame_c     = in_msg_c ? int_rdata_c : PAD;
    lfsr_step_c = {lfsr_q[3:0], ^(lfsr_q & taps_q)};
  end

  // Memory write arbitration: ciphertext while running, host otherwise.
  always_comb begin
    host_ok_c   = init || (state_q == S_IDLE) || (state_q == S_DONE);
    mem_we_c    = 1'b0;
    mem_waddr_c = waddr;
    mem_wdata_c = data_in;
    if ((state_q == S_RUN) && !init) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = AW'(CT_BASE) + AW'(idx_q);
      mem_wdata_c = frame_c ^ DW'(lfsr_q);
    end else if (wr_en && host_ok_c) begin
      mem_we_c    = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    taps_d  = taps_q;
    len_d   = len_q;
    pre_d   = pre_q;
    done_d  = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        len_d   = clamp_len(int_rdata_c);
        cnt_d   = 2'd1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd1:    pre_d  = clamp_pre(int_rdata_c);
          2'd2:    taps_d = pat_taps(int_rdata_c);
          2'd3: begin
            lfsr_d  = seed_of(int_rdata_c[LW-1:0]);
            idx_d   = '0;
            state_d = S_RUN;
          end
          default: cnt_d = 2'd1;
        endcase
      end
      S_RUN: begin
        lfsr_d = lfsr_step_c;
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(LAST_IDX)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= '0;
      taps_q  <= '0;
      len_q   <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      taps_q  <= taps_d;
      len_q   <= len_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule
